// File: rtl/mem_dma_engine_pkg.sv
// Shared definitions for the memory-side DMA engine: op codes, FSM states
// and the word stride used for address stepping.
`timescale 1ns/1ps
package mem_dma_pkg;

  localparam logic [1:0] OP_COPY   = 2'b00;
  localparam logic [1:0] OP_FILL   = 2'b01;
  localparam logic [1:0] OP_VERIFY = 2'b10;

  localparam logic [31:0] ADDR_STRIDE = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_SRC = 3'd1,
    ST_WR_DST = 3'd2,
    ST_RD_DST = 3'd3,
    ST_DONE   = 3'd4
  } dma_state_t;

endpackage

// File: rtl/mem_dma_engine_if.sv
// Single-port memory bus shared with the multi-cycle CPU. The engine is the
// master; the memory (or the CPU-side mux in front of it) is the slave.
// Mem_data is combinational and valid in the same cycle as Address/MemRead.
`timescale 1ns/1ps
interface mem_dma_engine_if;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Mem_data;

  modport master (output Address, output Write_data, output MemRead,
                  output MemWrite, input Mem_data);
  modport slave  (input Address, input Write_data, input MemRead,
                  input MemWrite, output Mem_data);
endinterface

// File: rtl/mem_dma_engine.sv
// Block copy / fill / verify engine on 32-bit words.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | waiting for start; bus outputs all zero
//   ST_RD_SRC | read word at src, capture into data register
//   ST_WR_DST | write captured word (copy) or fill_value (fill) to dst
//   ST_RD_DST | read word at dst and compare against captured word (verify)
//   ST_DONE   | one-cycle done pulse, then back to idle
//
// Every output is a flop loaded from the decode of the next state, so the
// bus and status lines are Moore outputs with no combinational path from
// start or Mem_data.
`timescale 1ns/1ps
module mem_dma_engine
  import mem_dma_pkg::*;
#(
  parameter int RAM_SIZE_BIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [31:0]           src_addr,
  input  logic [31:0]           dst_addr,
  input  logic [RAM_SIZE_BIT:0] word_count,
  input  logic [31:0]           fill_value,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [31:0]           mismatch_addr,
  mem_dma_engine_if.master      mem
);

  localparam int CW = RAM_SIZE_BIT + 1;

  dma_state_t    state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [31:0]   src_q, src_d;
  logic [31:0]   dst_q, dst_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   fill_q, fill_d;
  logic [31:0]   data_q, data_d;
  logic          err_q, err_d;
  logic [31:0]   mm_addr_q, mm_addr_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          bad_req;
  logic          last_word;

  assign bad_req = (op == 2'b11) ||
                   ((op != OP_FILL) && (src_addr[1:0] != 2'b00)) ||
                   (dst_addr[1:0] != 2'b00);
  assign last_word = (cnt_q == CW'(1));

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    data_d    = data_q;
    err_d     = err_q;
    mm_addr_d = mm_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d      = op;
          src_d     = src_addr;
          dst_d     = dst_addr;
          cnt_d     = word_count;
          fill_d    = fill_value;
          err_d     = 1'b0;
          mm_addr_d = 32'd0;
          if (bad_req) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (word_count == '0) begin
            state_d = ST_DONE;
          end else if (op == OP_FILL) begin
            state_d = ST_WR_DST;
          end else begin
            state_d = ST_RD_SRC;
          end
        end
      end
      ST_RD_SRC: begin
        data_d  = mem.Mem_data;
        state_d = (op_q == OP_VERIFY) ? ST_RD_DST : ST_WR_DST;
      end
      ST_WR_DST: begin
        dst_d = dst_q + ADDR_STRIDE;
        cnt_d = cnt_q - CW'(1);
        if (op_q != OP_FILL) src_d = src_q + ADDR_STRIDE;
        if (last_word)             state_d = ST_DONE;
        else if (op_q == OP_FILL)  state_d = ST_WR_DST;
        else                       state_d = ST_RD_SRC;
      end
      ST_RD_DST: begin
        if (mem.Mem_data != data_q) begin
          err_d     = 1'b1;
          mm_addr_d = dst_q;
          state_d   = ST_DONE;
        end else begin
          src_d   = src_q + ADDR_STRIDE;
          dst_d   = dst_q + ADDR_STRIDE;
          cnt_d   = cnt_q - CW'(1);
          state_d = last_word ? ST_DONE : ST_RD_SRC;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    done_d  = 1'b0;
    busy_d  = (state_d != ST_IDLE);
    addr_d  = 32'd0;
    wdata_d = 32'd0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    case (state_d)
      ST_RD_SRC: begin
        rd_d   = 1'b1;
        addr_d = src_d;
      end
      ST_WR_DST: begin
        wr_d    = 1'b1;
        addr_d  = dst_d;
        wdata_d = (op_d == OP_FILL) ? fill_d : data_d;
      end
      ST_RD_DST: begin
        rd_d   = 1'b1;
        addr_d = dst_d;
      end
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= 2'b00;
      src_q     <= 32'd0;
      dst_q     <= 32'd0;
      cnt_q     <= '0;
      fill_q    <= 32'd0;
      data_q    <= 32'd0;
      err_q     <= 1'b0;
      mm_addr_q <= 32'd0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cnt_q     <= cnt_d;
      fill_q    <= fill_d;
      data_q    <= data_d;
      err_q     <= err_d;
      mm_addr_q <= mm_addr_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = err_q;
  assign mismatch_addr  = mm_addr_q;
  assign mem.Address    = addr_q;
  assign mem.Write_data = wdata_q;
  assign mem.MemRead    = rd_q;
  assign mem.MemWrite   = wr_q;

endmodule

// File: tb/tb_mem_dma_engine.sv
// Bench for mem_dma_engine: 256-word memory model, directed cases plus
// randomized copy/fill/verify requests checked against a word-level model.
`timescale 1ns/1ps
module tb_mem_dma_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_addr = 32'd0;
  logic [31:0] dst_addr = 32'd0;
  logic [8:0]  word_count = 9'd0;
  logic [31:0] fill_value = 32'd0;
  logic        busy, done, error;
  logic [31:0] mismatch_addr;

  mem_dma_engine_if bus ();

  mem_dma_engine #(.RAM_SIZE_BIT(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_addr(src_addr), .dst_addr(dst_addr), .word_count(word_count),
    .fill_value(fill_value), .busy(busy), .done(done), .error(error),
    .mismatch_addr(mismatch_addr), .mem(bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic        poke_en = 1'b0;
  logic [7:0]  poke_idx = 8'd0;
  logic [31:0] poke_data = 32'd0;

  assign bus.Mem_data = mem[bus.Address[9:2]];

  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_data;
    else if (bus.MemWrite) mem[bus.Address[9:2]] <= bus.Write_data;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = idx[7:0]; poke_data = val;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  task automatic check_mem(input string tag);
    int diffs = 0;
    int first = -1;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) begin
        diffs++;
        if (first < 0) first = i;
      end
    if (diffs != 0) $display("memory differs first at word %0d", first);
    chk(tag, diffs, 0);
  endtask

  // Issue one request and check timing, status and memory contents.
  task automatic run_op(input logic [1:0] op_i, input logic [31:0] s, input logic [31:0] d,
                        input int n, input logic [31:0] f, input bit hold);
    int exp_cyc, got_cyc, busy_cnt, limit;
    logic exp_err, ovl, wr_seen, acc_seen, busy_after, done_after;
    logic [31:0] exp_mm;
    bit illegal;

    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    exp_err = 1'b0; exp_mm = 32'd0;
    illegal = (op_i == 2'b11) || (op_i != 2'b01 && s[1:0] != 2'b00) || (d[1:0] != 2'b00);
    if (illegal) begin
      exp_cyc = 1; exp_err = 1'b1;
    end else if (n == 0) begin
      exp_cyc = 1;
    end else if (op_i == 2'b00) begin
      for (int i = 0; i < n; i++)
        ref_mem[widx(d + 32'(4*i))] = ref_mem[widx(s + 32'(4*i))];
      exp_cyc = 2*n + 1;
    end else if (op_i == 2'b01) begin
      for (int i = 0; i < n; i++) ref_mem[widx(d + 32'(4*i))] = f;
      exp_cyc = n + 1;
    end else begin
      exp_cyc = 2*n + 1;
      for (int i = 0; i < n; i++)
        if (ref_mem[widx(s + 32'(4*i))] !== ref_mem[widx(d + 32'(4*i))]) begin
          exp_cyc = 2*(i+1) + 1;
          exp_err = 1'b1;
          exp_mm  = d + 32'(4*i);
          break;
        end
    end

    @(negedge clk);
    op = op_i; src_addr = s; dst_addr = d; word_count = n[8:0]; fill_value = f;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;

    got_cyc = -1; busy_cnt = 0; ovl = 0; wr_seen = 0; acc_seen = 0;
    busy_after = 1'b1; done_after = 1'b1;
    limit = exp_cyc + 20;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (got_cyc >= 0 && c == got_cyc + 1) begin
        busy_after = busy; done_after = done;
        break;
      end
      if (busy) busy_cnt++;
      if (bus.MemRead && bus.MemWrite) ovl = 1'b1;
      if (bus.MemWrite) wr_seen = 1'b1;
      if (bus.MemRead || bus.MemWrite) acc_seen = 1'b1;
      if (done && got_cyc < 0) begin
        got_cyc = c;
        chk("error", error, exp_err);
        chk("mismatch_addr", mismatch_addr, exp_mm);
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("done_seen", (got_cyc >= 0), 1);
    chk("done_cycle", got_cyc, exp_cyc);
    chk("busy_cycles", busy_cnt, exp_cyc);
    chk("busy_after_done", busy_after, 0);
    chk("done_pulse_width", done_after, 0);
    chk("rd_wr_overlap", ovl, 0);
    if (op_i == 2'b10) chk("verify_no_write", wr_seen, 0);
    if (illegal || n == 0) chk("no_access", acc_seen, 0);
    check_mem("memory");
  endtask

  initial begin
    int r, n;
    logic [1:0]  o;
    logic [31:0] s, d, f;

    #1;
    chk("rst_status", {27'd0, busy, done, error, bus.MemRead, bus.MemWrite}, 0);
    chk("rst_addr", bus.Address, 0);
    chk("rst_wdata", bus.Write_data, 0);
    chk("rst_mm", mismatch_addr, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 256; i++) poke(i, $urandom);
    poke(32, 32'h11); poke(33, 32'h22); poke(34, 32'h33); poke(35, 32'h44);

    run_op(2'b00, 32'h80, 32'h100, 4, 32'h0, 0);
    chk("copy_w66", mem[66], 32'h33);
    run_op(2'b01, 32'h0, 32'h200, 3, 32'hDEADBEEF, 0);
    chk("fill_w130", mem[130], 32'hDEADBEEF);
    poke(66, 32'h0);
    run_op(2'b10, 32'h80, 32'h100, 4, 32'h0, 0);
    run_op(2'b00, 32'h80, 32'h100, 0, 32'h0, 0);
    run_op(2'b00, 32'h82, 32'h100, 4, 32'h0, 0);
    run_op(2'b11, 32'h80, 32'h100, 4, 32'h0, 0);
    run_op(2'b01, 32'h0, 32'h102, 2, 32'h5, 0);
    run_op(2'b00, 32'h80, 32'h180, 3, 32'h0, 1);
    run_op(2'b01, 32'h0, 32'h0, 256, 32'hA5A5_0F0F, 0);

    // Reset during the third destination write of an 8-word copy.
    for (int i = 0; i < 8; i++) poke(32 + i, 32'h100 + i);
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    ref_mem[192] = mem[32];
    ref_mem[193] = mem[33];
    @(negedge clk);
    op = 2'b00; src_addr = 32'h80; dst_addr = 32'h300; word_count = 9'd8; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_reset_write", {bus.MemWrite, bus.Address[15:0]}, {1'b1, 16'h308});
    reset = 1'b1;
    #1;
    chk("midrst_status", {27'd0, busy, done, error, bus.MemRead, bus.MemWrite}, 0);
    chk("midrst_addr", bus.Address, 0);
    chk("midrst_wdata", bus.Write_data, 0);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    check_mem("reset_partial_copy");
    run_op(2'b01, 32'h0, 32'h300, 2, 32'h1234_5678, 0);

    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      o = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      s = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      d = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 7) == 0) s[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) d[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) begin
        s = s + 32'hFFFF_F000;
        d = d + 32'h0001_0000;
      end
      n = $urandom_range(0, 12);
      f = $urandom;
      if (o == 2'b10 && $urandom_range(0, 1) == 1) begin
        for (int i = 0; i < n; i++) poke(widx(d + 32'(4*i)), mem[widx(s + 32'(4*i))]);
        if (n > 0 && $urandom_range(0, 1) == 1)
          poke(widx(d + 32'(4*$urandom_range(0, n-1))), $urandom);
      end
      run_op(o, s, d, n, f, $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_dma_engine.md
# mem_dma_engine

Bus-initiator block driving the single-port instruction/data memory port (Address, Write_data, MemRead, MemWrite, Mem_data) of the multi-cycle CPU. It performs block copy, block fill and block verify operations on 32-bit words without CPU involvement. It sits on the memory-side port in place of the CPU while busy; the CPU-side mux selecting between the two is outside this block.

## Interface
- RAM_SIZE_BIT, 8, log2 of memory depth in words; word_count is RAM_SIZE_BIT+1 bits wide so a full-memory transfer is expressible.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 copy, 01 fill, 10 verify, 11 illegal.
- src_addr  input  32  source byte address (copy/verify).
- dst_addr  input  32  destination byte address (all ops).
- word_count  input  RAM_SIZE_BIT+1  number of words.
- fill_value  input  32  pattern for fill.
- busy  output  1  high in every non-IDLE state.
- done  output  1  one-cycle pulse on completion.
- error  output  1  sticky until next accepted start.
- mismatch_addr  output  32  dst address of first verify mismatch; sticky like error.
- Address  output  32  memory byte address.
- Write_data  output  32  memory write data.
- MemRead  output  1  memory read enable.
- MemWrite  output  1  memory write enable.
- Mem_data  input  32  combinational read data, valid in the same cycle as MemRead/Address.

## Operation
- States: IDLE, RD_SRC, WR_DST, RD_DST, DONE.
- IDLE + start: latch op, src, dst, count, fill_value; clear error and mismatch_addr. Next state:
  - DONE with error=1 if op=11, or src_addr[1:0]≠0 (copy/verify only), or dst_addr[1:0]≠0.
  - DONE without error if word_count=0.
  - Otherwise RD_SRC for copy/verify, WR_DST for fill.
- Copy:
  - RD_SRC drives MemRead=1, Address=src; Mem_data is captured into a data register at the edge; next state WR_DST.
  - WR_DST drives MemWrite=1, Address=dst, Write_data=captured data.
  - Then src+=4, dst+=4, count−=1; next state DONE if count becomes 0, else RD_SRC.
- Fill: WR_DST each cycle with Write_data=fill_value; dst+=4, count−=1; stays in WR_DST until count reaches 0, then DONE.
- Verify:
  - RD_SRC captures data, then RD_DST.
  - RD_DST drives MemRead=1, Address=dst and compares Mem_data to the captured data.
  - On mismatch: error=1, mismatch_addr=dst, next state DONE (stop at first mismatch).
  - On match: advance src, dst and count as in copy; next state RD_SRC, or DONE when count reaches 0.
- DONE: done=1 for one cycle, then IDLE.
- Addresses increment modulo 2^32; wrap beyond memory depth is resolved by the memory's index truncation and is not detected.
- MemRead and MemWrite are never high together. Outside access states, Address, Write_data, MemRead and MemWrite are all 0.
- start while busy is ignored.

## Timing
- Reset values: busy, done, error, MemRead, MemWrite = 0; mismatch_addr, Address, Write_data = 0; state IDLE. Reset asserted mid-operation clears everything immediately; a partially completed copy or fill is left as is.
- Cycle 0 is the edge where start is sampled. The first access is in cycle 1.
- done is high in cycle:
  - 2N+1 for copy, and for verify with all words matching.
  - N+1 for fill.
  - 1 for zero count or an illegal request.
  - 2k+1 for verify with the first mismatch at word k (1-based).
- Throughput: copy and verify take 2 cycles/word; fill takes 1 cycle/word.
- busy falls in the cycle after done. start may be accepted in that cycle (IDLE).
- All outputs are registered-state-decoded (Moore). No output depends combinationally on start.

## Structure
- Package mem_dma_pkg holds: op encodings (OP_COPY, OP_FILL, OP_VERIFY), the state enum, and the address stride constant 4.
- Single module; no sub-module. The compare is a single equality and is kept inline.

## Test plan
- Copy: preload words 32..35 = 0x11,0x22,0x33,0x44; op=00, src=0x80, dst=0x100, count=4. Required: words 64..67 equal the preload; done in cycle 9; busy for cycles 1–9; error=0.
- Fill: op=01, dst=0x200, count=3, fill_value=0xDEADBEEF. Required: words 128..130 = 0xDEADBEEF, word 131 unchanged; done in cycle 4.
- Verify mismatch: words 32..35 vs 64..67 identical except word 66 = 0x0. Required: error=1, mismatch_addr=0x108, done in cycle 7; no MemWrite at any time.
- Boundary requests:
  - count=0: done in cycle 1, no memory access.
  - src=0x82 with op=00: done in cycle 1, error=1.
  - op=11: done in cycle 1, error=1.
  - start held high while busy: no restart.
- Reset mid-op: assert reset during the third WR_DST of an 8-word copy. Required: outputs zero immediately; exactly 2 destination words are written; after release the block is IDLE and accepts a new start.
